// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage with a single outstanding instruction-memory request
// and an IF/ID pipeline register feeding decode.
//
// A four-state controller sequences memory requests:
//   IDLE  - one cycle after reset, no request.
//   WAIT  - request open at the current PC.
//   HOLD  - a response arrived during a decode stall and sits in a one-entry
//           buffer until the stall drops. No request is issued.
//   DRAIN - a redirect abandoned an open request. Its address is kept on the
//           bus until the stale response arrives and is thrown away.
//
// Ports
//   clk                   : single clock, rising edge
//   reset                 : asynchronous, active-high
//   stall                 : decode hazard; IF/ID and PC hold
//   flush                 : squash IF/ID to a bubble
//   redirect, redirect_pc : taken branch/jump; fetch restarts at the target
//   imem_req, imem_addr   : level request and word-aligned address
//   imem_valid/imem_rdata : one-cycle response completing the open request
//   instruction_to_decode, if_id_pc, if_id_pc_plus4, if_id_valid : IF/ID
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_to_decode,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state_p0;
    state_t              state_nxt;
    logic [DATA_W-1:0]   pc_p0;
    logic [DATA_W-1:0]   pc_nxt;
    logic [DATA_W-1:0]   drain_addr_p0;
    logic [DATA_W-1:0]   drain_addr_nxt;
    logic [DATA_W-1:0]   hold_instr_p0;
    logic [DATA_W-1:0]   hold_instr_nxt;
    logic                ifid_load;
    logic [DATA_W-1:0]   ifid_instr_nxt;

    logic [DATA_W-1:0]   ifid_instr_p1;
    logic [DATA_W-1:0]   ifid_pc_p1;
    logic [DATA_W-1:0]   ifid_pc_plus4_p1;
    logic                vld_p1;

    function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
        return addr & ~(DATA_W'(3));
    endfunction

    // Wraps naturally modulo 2^32.
    function automatic logic [DATA_W-1:0] pc_incr(input logic [DATA_W-1:0] addr);
        return addr + DATA_W'(4);
    endfunction

    // Fetch control: next state, next PC, and whether IF/ID loads this cycle.
    always_comb begin
        state_nxt      = state_p0;
        pc_nxt         = pc_p0;
        drain_addr_nxt = drain_addr_p0;
        hold_instr_nxt = hold_instr_p0;
        ifid_load      = 1'b0;
        ifid_instr_nxt = imem_rdata;

        case (state_p0)
            IDLE: begin
                state_nxt = WAIT;
                if (redirect) begin
                    pc_nxt = word_align(redirect_pc);
                end
            end

            WAIT: begin
                if (redirect) begin
                    pc_nxt = word_align(redirect_pc);
                    if (imem_valid) begin
                        // Response lands in the same cycle: drop it and
                        // issue at the new PC immediately.
                        state_nxt = WAIT;
                    end else begin
                        // Request still open: keep its address on the bus
                        // until the stale response has been absorbed.
                        state_nxt      = DRAIN;
                        drain_addr_nxt = pc_p0;
                    end
                end else if (imem_valid) begin
                    if (stall) begin
                        hold_instr_nxt = imem_rdata;
                        state_nxt      = HOLD;
                    end else begin
                        ifid_load      = 1'b1;
                        ifid_instr_nxt = imem_rdata;
                        pc_nxt         = pc_incr(pc_p0);
                    end
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_nxt    = word_align(redirect_pc);
                    state_nxt = WAIT;
                end else if (!stall) begin
                    ifid_load      = 1'b1;
                    ifid_instr_nxt = hold_instr_p0;
                    pc_nxt         = pc_incr(pc_p0);
                    state_nxt      = WAIT;
                end
            end

            DRAIN: begin
                if (redirect) begin
                    pc_nxt = word_align(redirect_pc);
                end
                if (imem_valid) begin
                    state_nxt = WAIT;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---- stage p0: fetch control state ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p0 <= IDLE;
            pc_p0    <= RESET_PC;
        end else begin
            state_p0 <= state_nxt;
            pc_p0    <= pc_nxt;
        end
    end

    // The buffer and the drain address are qualified by state, so they need
    // no reset.
    always_ff @(posedge clk) begin
        drain_addr_p0 <= drain_addr_nxt;
        hold_instr_p0 <= hold_instr_nxt;
    end

    // ---- stage p1: IF/ID register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_instr_p1    <= NOP_INSTR;
            ifid_pc_p1       <= '0;
            ifid_pc_plus4_p1 <= '0;
            vld_p1           <= 1'b0;
        end else if (flush) begin
            // Bubble in; the PC fields are left as they were.
            ifid_instr_p1 <= NOP_INSTR;
            vld_p1        <= 1'b0;
        end else if (ifid_load) begin
            ifid_instr_p1    <= ifid_instr_nxt;
            ifid_pc_p1       <= pc_p0;
            ifid_pc_plus4_p1 <= pc_incr(pc_p0);
            vld_p1           <= 1'b1;
        end
    end

    assign imem_req  = (state_p0 == WAIT) || (state_p0 == DRAIN);
    assign imem_addr = (state_p0 == DRAIN) ? drain_addr_p0 : pc_p0;

    assign instruction_to_decode = ifid_instr_p1;
    assign if_id_pc              = ifid_pc_p1;
    assign if_id_pc_plus4        = ifid_pc_plus4_p1;
    assign if_id_valid           = vld_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. A behavioural instruction memory answers
// each request after a programmable latency with rdata = addr ^ 32'hA5A5_0000.
// Every delivered response that should reach decode is queued. Each new IF/ID
// instruction is popped from the queue and compared.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_to_decode;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .stall                (stall),
        .flush                (flush),
        .redirect             (redirect),
        .redirect_pc          (redirect_pc),
        .imem_req             (imem_req),
        .imem_addr            (imem_addr),
        .imem_valid           (imem_valid),
        .imem_rdata           (imem_rdata),
        .instruction_to_decode(instruction_to_decode),
        .if_id_pc             (if_id_pc),
        .if_id_pc_plus4       (if_id_pc_plus4),
        .if_id_valid          (if_id_valid)
    );

    always #5 clk = ~clk;

    int          assert_cnt = 0;
    int          fail_cnt   = 0;

    // memory model state
    int          mem_lat     = 1;
    int          mem_cnt     = 0;
    bit          mem_pending = 0;
    logic [31:0] mem_addr    = '0;
    int          sb_drop     = 0;

    // scoreboard
    logic [31:0] sb_q[$];
    bit          prev_valid = 0;
    logic [31:0] prev_pc    = '0;
    bit          popped     = 0;
    int          pop_cnt    = 0;
    logic [31:0] last_pop_pc    = '0;
    logic [31:0] last_pop_plus4 = '0;

    // One clock: after the edge settles, compare any new IF/ID contents and
    // advance the memory model.
    task automatic tick();
        logic [31:0] exp_addr;
        @(posedge clk);
        #1;
        popped = 0;
        if (if_id_valid === 1'b1 && (!prev_valid || if_id_pc !== prev_pc)) begin
            popped = 1;
            pop_cnt++;
            last_pop_pc    = if_id_pc;
            last_pop_plus4 = if_id_pc_plus4;
            assert_cnt++;
            if (sb_q.size() == 0) begin
                fail_cnt++;
                $display("FAIL sb_unexpected: IF/ID pc=%h instr=%h, no instruction expected", if_id_pc, instruction_to_decode);
            end else begin
                exp_addr = sb_q.pop_front();
                if (instruction_to_decode !== (exp_addr ^ KEY) || if_id_pc !== exp_addr ||
                    if_id_pc_plus4 !== exp_addr + 32'd4) begin
                    fail_cnt++;
                    $display("FAIL sb_ifid: got instr=%h pc=%h pc4=%h, expected instr=%h pc=%h pc4=%h",
                             instruction_to_decode, if_id_pc, if_id_pc_plus4,
                             exp_addr ^ KEY, exp_addr, exp_addr + 32'd4);
                end
            end
        end
        prev_valid = (if_id_valid === 1'b1);
        prev_pc    = if_id_pc;

        if (imem_valid) begin
            imem_valid  = 1'b0;
            mem_pending = 0;
        end
        if (mem_pending) begin
            assert_cnt++;
            if (imem_req !== 1'b1 || imem_addr !== mem_addr) begin
                fail_cnt++;
                $display("FAIL req_stable: req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, mem_addr);
            end
        end else if (imem_req === 1'b1) begin
            mem_pending = 1;
            mem_addr    = imem_addr;
            mem_cnt     = mem_lat;
        end
        if (mem_pending) begin
            if (mem_cnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem_addr ^ KEY;
                if (sb_drop > 0) sb_drop--;
                else sb_q.push_back(mem_addr);
            end else begin
                mem_cnt--;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 0; flush = 0; redirect = 0; redirect_pc = '0;
        imem_valid = 0; imem_rdata = '0;
        tick();
        tick();
        assert_cnt++;
        if (imem_req !== 1'b0 || instruction_to_decode !== NOP || if_id_pc !== 32'd0 ||
            if_id_pc_plus4 !== 32'd0 || if_id_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_state: req=%b instr=%h pc=%h pc4=%h vld=%b, expected 0 %h 0 0 0",
                     imem_req, instruction_to_decode, if_id_pc, if_id_pc_plus4, if_id_valid, NOP);
        end
        reset = 1'b0;
        tick();
        assert_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            fail_cnt++;
            $display("FAIL first_req: req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential_and_stall();
        int n;
        mem_lat = 1;
        n = 0;
        while (!(imem_valid === 1'b1 && mem_addr == 32'd8) && n < 20) begin tick(); n++; end
        assert_cnt++;
        if (!(imem_valid === 1'b1 && mem_addr == 32'd8) || pop_cnt != 2 || if_id_pc !== 32'd4) begin
            fail_cnt++;
            $display("FAIL seq_fetch: pops=%0d ifid_pc=%h, expected 2 pops ending at pc 00000004", pop_cnt, if_id_pc);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            assert_cnt++;
            if (imem_req !== 1'b0 || if_id_pc !== 32'd4 || if_id_valid !== 1'b1) begin
                fail_cnt++;
                $display("FAIL stall_hold: cyc=%0d req=%b ifid_pc=%h vld=%b, expected req=0 pc=00000004 vld=1",
                         i, imem_req, if_id_pc, if_id_valid);
            end
        end
        stall = 1'b0;
        tick();
        assert_cnt++;
        if (if_id_pc !== 32'd8 || if_id_valid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'd12 || pop_cnt != 3) begin
            fail_cnt++;
            $display("FAIL stall_release: ifid_pc=%h vld=%b req=%b addr=%h pops=%0d, expected 00000008 1 1 0000000c 3",
                     if_id_pc, if_id_valid, imem_req, imem_addr, pop_cnt);
        end
    endtask

    task automatic test_redirect_drain();
        int n;
        bit saw16;
        saw16 = 0;
        mem_lat = 2;
        n = 0;
        while (!(mem_pending && mem_addr == 32'd16 && imem_valid === 1'b0) && n < 20) begin tick(); n++; end
        redirect = 1'b1; redirect_pc = 32'h0000_0103; sb_drop = 1;
        tick();
        redirect = 1'b0;
        assert_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd16) begin
            fail_cnt++;
            $display("FAIL drain_addr: req=%b addr=%h, expected 1 00000010", imem_req, imem_addr);
        end
        n = 0;
        while (!(imem_req === 1'b1 && imem_addr == 32'h100) && n < 10) begin
            tick(); n++;
            if (if_id_valid === 1'b1 && if_id_pc == 32'd16) saw16 = 1;
        end
        assert_cnt++;
        if (imem_addr !== 32'h0000_0100 || sb_drop != 0) begin
            fail_cnt++;
            $display("FAIL redirect_req: addr=%h drops_left=%0d, expected 00000100 0", imem_addr, sb_drop);
        end
        n = 0;
        while (!(if_id_valid === 1'b1 && if_id_pc == 32'h100) && n < 10) begin
            tick(); n++;
            if (if_id_valid === 1'b1 && if_id_pc == 32'd16) saw16 = 1;
        end
        assert_cnt++;
        if (saw16 || if_id_pc !== 32'h100 || if_id_pc_plus4 !== 32'h104) begin
            fail_cnt++;
            $display("FAIL redirect_ifid: saw_pc16=%0d ifid_pc=%h pc4=%h, expected 0 00000100 00000104",
                     saw16, if_id_pc, if_id_pc_plus4);
        end
    endtask

    task automatic test_flush_hold();
        int n;
        mem_lat = 1;
        n = 0;
        while (!(imem_valid === 1'b1 && mem_addr == 32'h104) && n < 20) begin tick(); n++; end
        stall = 1'b1; flush = 1'b1;
        tick();
        assert_cnt++;
        if (instruction_to_decode !== NOP || if_id_valid !== 1'b0 || if_id_pc !== 32'h100 || imem_req !== 1'b0) begin
            fail_cnt++;
            $display("FAIL flush_stall: instr=%h vld=%b pc=%h req=%b, expected %h 0 00000100 0",
                     instruction_to_decode, if_id_valid, if_id_pc, imem_req, NOP);
        end
        flush = 1'b0;
        tick();
        assert_cnt++;
        if (imem_req !== 1'b0 || if_id_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL flush_held: req=%b vld=%b, expected 0 0", imem_req, if_id_valid);
        end
        stall = 1'b0;
        tick();
        assert_cnt++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h104 || instruction_to_decode !== (32'h104 ^ KEY) ||
            imem_req !== 1'b1 || imem_addr !== 32'h108) begin
            fail_cnt++;
            $display("FAIL hold_release: vld=%b pc=%h instr=%h req=%b addr=%h, expected 1 00000104 %h 1 00000108",
                     if_id_valid, if_id_pc, instruction_to_decode, imem_req, imem_addr, 32'h104 ^ KEY);
        end
    endtask

    task automatic test_wrap();
        int n;
        bit got_top;
        bit got_zero;
        logic [31:0] dropped;
        got_top = 0; got_zero = 0;
        n = 0;
        while (!(imem_valid === 1'b1 && mem_addr == 32'h108) && n < 20) begin tick(); n++; end
        // Redirect coincides with the response: that response never reaches decode.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        dropped = sb_q.pop_back();
        tick();
        redirect = 1'b0;
        assert_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || dropped !== 32'h108) begin
            fail_cnt++;
            $display("FAIL redirect_hit: req=%b addr=%h, expected 1 fffffffc", imem_req, imem_addr);
        end
        n = 0;
        while (!got_zero && n < 20) begin
            tick(); n++;
            if (popped && last_pop_pc == 32'hFFFF_FFFC) begin
                got_top = 1;
                assert_cnt++;
                if (last_pop_plus4 !== 32'd0) begin
                    fail_cnt++;
                    $display("FAIL wrap_plus4: got %h, expected 00000000", last_pop_plus4);
                end
            end
            if (popped && last_pop_pc == 32'd0) got_zero = 1;
        end
        assert_cnt++;
        if (!got_top || !got_zero) begin
            fail_cnt++;
            $display("FAIL wrap_order: saw_fffffffc=%0d saw_00000000=%0d, expected 1 1", got_top, got_zero);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        mem_lat = 0;
        start = pop_cnt;
        for (int i = 0; i < 10; i++) tick();
        assert_cnt++;
        if (pop_cnt - start < 5) begin
            fail_cnt++;
            $display("FAIL back_to_back: %0d instructions in 10 cycles, expected at least 5", pop_cnt - start);
        end
    endtask

    task automatic test_async_reset();
        int n;
        int start;
        mem_lat = 3;
        n = 0;
        while (!(mem_pending && imem_valid === 1'b0 && imem_req === 1'b1) && n < 20) begin tick(); n++; end
        #2;
        reset = 1'b1;
        #1;
        assert_cnt++;
        if (imem_req !== 1'b0 || instruction_to_decode !== NOP || if_id_pc !== 32'd0 ||
            if_id_pc_plus4 !== 32'd0 || if_id_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL async_reset: req=%b instr=%h pc=%h pc4=%h vld=%b, expected 0 %h 0 0 0",
                     imem_req, instruction_to_decode, if_id_pc, if_id_pc_plus4, if_id_valid, NOP);
        end
        imem_valid = 1'b0; mem_pending = 0; sb_drop = 0; sb_q.delete(); prev_valid = 0;
        tick();
        tick();
        reset = 1'b0;
        mem_lat = 1;
        start = pop_cnt;
        n = 0;
        while (pop_cnt == start && n < 20) begin tick(); n++; end
        assert_cnt++;
        if (pop_cnt == start || last_pop_pc !== 32'd0) begin
            fail_cnt++;
            $display("FAIL restart_pc: first pc after reset=%h pops=%0d, expected 00000000 1", last_pop_pc, pop_cnt - start);
        end
    endtask

    initial begin
        test_reset();
        test_sequential_and_stall();
        test_redirect_drain();
        test_flush_hold();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
